mips_multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the MIPS datapath: the instruction memory, register file, ALU and main memory already in the design.
- Owns the PC and instruction register.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath control lines (Aluout-style ALUOp, MemR, MemW, RegW, MemToReg, alusrc, regdest) one phase at a time.
- Adds a memory-ready handshake with timeout, plus halt and illegal-opcode detection.

---
 rtl/mips_multicycle_ctrl.sv | 136 +++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS sequencer owning PC/IR, driving datapath
// control per phase, with memory-ready timeout, halt and illegal-opcode detection.
module mips_multicycle_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] instr,
   input  logic        alu_zero,
   input  logic        mem_ready,
   output logic [31:0] pc,
   output logic [31:0] ir,
   output logic [1:0]  aluop,
   output logic        MemR,
   output logic        MemW,
   output logic        RegW,
   output logic        MemToReg,
   output logic        alusrc,
   output logic        regdest,
   output logic [2:0]  state,
   output logic        halted,
   output logic [1:0]  err
);
   localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                          S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;
   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_ADDI = 6'b001000, OP_BEQ = 6'b000100, OP_J = 6'b000010,
                          OP_HALT = 6'b111111;
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   logic [2:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d;
   logic [1:0]  err_q, err_d;
   logic [7:0]  wait_q, wait_d;
   logic [31:0] pc_plus4;
   logic [5:0]  op;
   logic        is_r, is_lw, is_sw, is_addi, is_beq;

   assign pc_plus4 = pc_q + 32'd4;
   assign op       = ir_q[31:26];
   assign is_r     = op == OP_R;
   assign is_lw    = op == OP_LW;
   assign is_sw    = op == OP_SW;
   assign is_addi  = op == OP_ADDI;
   assign is_beq   = op == OP_BEQ;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         err_q   <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         err_q   <= err_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      err_d   = err_q;
      wait_d  = wait_q;
      case (state_q)
         S_IDLE, S_HALT: if (start) begin
            state_d = S_FETCH;
            pc_d    = RESET_PC;
            err_d   = '0;
         end
         S_FETCH: begin
            ir_d    = instr;
            state_d = S_DECODE;
         end
         S_DECODE: case (op)
            OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ: state_d = S_EXEC;
            OP_J: begin
               pc_d    = {pc_plus4[31:28], ir_q[25:0], 2'b00};
               state_d = S_FETCH;
            end
            OP_HALT: state_d = S_HALT;
            default: begin
               err_d[0] = 1'b1;
               state_d  = S_HALT;
            end
         endcase
         S_EXEC: begin
            if (is_beq) begin
               pc_d    = alu_zero ? pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00} : pc_plus4;
               state_d = S_FETCH;
            end else
               state_d = (is_lw || is_sw) ? S_MEM : S_WB;
         end
         S_MEM: begin
            if (mem_ready) begin
               wait_d  = '0;
               pc_d    = is_sw ? pc_plus4 : pc_q;
               state_d = is_sw ? S_FETCH : S_WB;
            end else if (wait_q == WAIT_LAST) begin
               // the MAX_WAIT-th unanswered cycle gives up
               wait_d   = '0;
               err_d[1] = 1'b1;
               state_d  = S_HALT;
            end else
               wait_d = wait_q + 8'd1;
         end
         S_WB: begin
            pc_d    = pc_plus4;
            state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      aluop    = (state_q == S_EXEC) ? (is_r ? 2'b10 : is_beq ? 2'b01 : 2'b00) : 2'b00;
      alusrc   = (state_q == S_EXEC && (is_lw || is_sw || is_addi)) || state_q == S_MEM ||
                 (state_q == S_WB && is_addi);
      MemR     = state_q == S_MEM && is_lw;
      MemW     = state_q == S_MEM && is_sw;
      RegW     = state_q == S_WB;
      MemToReg = state_q == S_WB && is_lw;
      regdest  = state_q == S_WB && is_r;
      halted   = state_q == S_HALT;
      state    = state_q;
      pc       = pc_q;
      ir       = ir_q;
      err      = err_q;
   end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed instruction sequences with hand-computed expectations.
module tb_mips_multicycle_ctrl;
   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, alu_zero = 1'b0, mem_ready = 1'b0;
   logic [31:0] instr = '0;
   logic [31:0] pc, ir;
   logic [1:0]  aluop, err;
   logic        MemR, MemW, RegW, MemToReg, alusrc, regdest, halted;
   logic [2:0]  state;
   logic [7:0]  ctl;
   int          n_cmp = 0, n_bad = 0;

   localparam logic [31:0] I_ADD = 32'h012A4020, I_LW = 32'h8D280004, I_BEQ = 32'h1109FFFF,
                           I_J = 32'h08000010, I_SW = 32'hAD280008, I_BAD = 32'h54000000;

   mips_multicycle_ctrl #(.RESET_PC(32'h0), .MAX_WAIT(15)) dut (
      .clk(clk), .reset(reset), .start(start), .instr(instr), .alu_zero(alu_zero),
      .mem_ready(mem_ready), .pc(pc), .ir(ir), .aluop(aluop), .MemR(MemR), .MemW(MemW),
      .RegW(RegW), .MemToReg(MemToReg), .alusrc(alusrc), .regdest(regdest),
      .state(state), .halted(halted), .err(err)
   );

   always #5 clk = ~clk;
   assign ctl = {aluop, MemR, MemW, RegW, MemToReg, alusrc, regdest};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      #1;
      chk("rst_state", state, 0);
      chk("rst_pc", pc, 0);
      chk("rst_ir", ir, 0);
      chk("rst_err", err, 0);
      chk("rst_ctl", ctl, 0);
      step();
      reset = 1'b0;
      step();
      chk("idle_hold", state, 0);
      // add $8,$9,$10
      start = 1'b1;
      step();
      start = 1'b0;
      chk("add_fetch", state, 1);
      instr = I_ADD;
      step();
      chk("add_decode", state, 2);
      chk("add_ir", ir, I_ADD);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("add_exec", state, 3);
      chk("add_exec_ctl", ctl, 8'h80);
      step();
      chk("add_wb", state, 5);
      chk("add_wb_ctl", ctl, 8'h09);
      step();
      chk("add_done_state", state, 1);
      chk("add_done_pc", pc, 4);
      // lw with three wait cycles
      instr = I_LW;
      step();
      step();
      chk("lw_exec_ctl", ctl, 8'h02);
      step();
      chk("lw_mem", state, 4);
      chk("lw_mem_ctl1", ctl, 8'h22);
      step();
      chk("lw_mem_ctl2", ctl, 8'h22);
      step();
      chk("lw_mem_ctl3", ctl, 8'h22);
      mem_ready = 1'b1;
      #1;
      chk("lw_mem_ctl4", ctl, 8'h22);
      step();
      mem_ready = 1'b0;
      chk("lw_wb", state, 5);
      chk("lw_wb_ctl", ctl, 8'h0C);
      step();
      chk("lw_done_pc", pc, 8);
      chk("lw_err", err, 0);
      // beq taken: 8 + 4 - 4
      instr = I_BEQ;
      step();
      step();
      chk("beq_exec_ctl", ctl, 8'h40);
      alu_zero = 1'b1;
      step();
      chk("beq_t_state", state, 1);
      chk("beq_t_pc", pc, 8);
      step();
      step();
      alu_zero = 1'b0;
      step();
      chk("beq_nt_pc", pc, 12);
      // j to 0x40 skips EXEC
      instr = I_J;
      step();
      chk("j_decode", state, 2);
      step();
      chk("j_state", state, 1);
      chk("j_pc", pc, 32'h40);
      // sw timeout
      instr = I_SW;
      step();
      step();
      step();
      chk("sw_mem_ctl", ctl, 8'h12);
      cnt = 0;
      for (int k = 0; k < 40 && state == 4; k++) begin
         if (MemW) cnt++;
         step();
      end
      chk("sw_memw_cycles", cnt, 15);
      chk("sw_to_state", state, 6);
      chk("sw_to_err", err, 2);
      chk("sw_to_halted", halted, 1);
      chk("sw_to_ctl", ctl, 0);
      chk("sw_to_pc", pc, 32'h40);
      step();
      chk("halt_pc_frozen", pc, 32'h40);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_state", state, 1);
      chk("restart_pc", pc, 0);
      chk("restart_err", err, 0);
      // illegal opcode
      instr = I_BAD;
      step();
      step();
      chk("bad_state", state, 6);
      chk("bad_err", err, 1);
      chk("bad_halted", halted, 1);
      // async reset in MEM of lw, after one add so pc is nonzero
      start = 1'b1;
      step();
      start = 1'b0;
      instr = I_ADD;
      for (int k = 0; k < 4; k++) step();
      chk("pre_rst_pc", pc, 4);
      instr = I_LW;
      for (int k = 0; k < 3; k++) step();
      chk("pre_rst_memr", MemR, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_memr", MemR, 0);
      chk("arst_state", state, 0);
      chk("arst_pc", pc, 0);
      chk("arst_ir", ir, 0);
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
